// File: rtl/seq_divider.sv
// seq_divider: multi-cycle signed divider (restoring, one quotient bit per cycle).
// A start in IDLE captures magnitudes and signs. The operation then runs 32 RUN cycles and
// one FIX cycle that applies the signs. Divide-by-zero and the single overflow case
// (MIN / -1) finish in one edge and raise data_exception.
// Optional feature: define DIV_REMAINDER_EN to add the data_remainder output. The
// remainder takes the sign of the dividend.
module seq_divider #(
    parameter int WIDTH = 32
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             ctrl_DIV,
    input  logic [WIDTH-1:0] data_operandA,
    input  logic [WIDTH-1:0] data_operandB,
    output logic [WIDTH-1:0] data_result,
    output logic             data_exception,
    output logic             data_resultRDY,
`ifdef DIV_REMAINDER_EN
    output logic [WIDTH-1:0] data_remainder,
`endif
    output logic             busy
);

    localparam int CW = $clog2(WIDTH) + 1;
    localparam logic [CW-1:0]    LAST_STEP = CW'(WIDTH - 1);
    localparam logic [WIDTH-1:0] MIN_VAL   = {1'b1, {(WIDTH-1){1'b0}}};
    localparam logic [WIDTH-1:0] ALL_ONES  = {WIDTH{1'b1}};

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        FIX  = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [CW-1:0]    count_q, count_d;
    logic [WIDTH-1:0] rem_q, rem_d;       // partial remainder (magnitude)
    logic [WIDTH-1:0] quo_q, quo_d;       // dividend shifts out, quotient shifts in
    logic [WIDTH-1:0] div_q, div_d;       // divisor magnitude
    logic             neg_q_q, neg_q_d;   // quotient must be negated
    logic [WIDTH-1:0] result_q, result_d;
    logic             exc_q, exc_d;
    logic             rdy_q, rdy_d;
`ifdef DIV_REMAINDER_EN
    logic             neg_a_q, neg_a_d;   // dividend was negative
    logic [WIDTH-1:0] remout_q, remout_d;
`endif

    logic [WIDTH-1:0] abs_a;
    logic [WIDTH-1:0] abs_b;
    logic [WIDTH:0]   partial;            // {rem, next dividend bit}
    logic [WIDTH:0]   diff;               // trial subtraction, bit WIDTH is the borrow

    // Operand magnitudes and the WIDTH+1-bit trial subtractor.
    always_comb begin
        abs_a   = data_operandA[WIDTH-1] ? (~data_operandA + 1'b1) : data_operandA;
        abs_b   = data_operandB[WIDTH-1] ? (~data_operandB + 1'b1) : data_operandB;
        partial = {rem_q, quo_q[WIDTH-1]};
        diff    = partial - {1'b0, div_q};
    end

    // Next-state and datapath logic; every register holds unless a state updates it.
    always_comb begin
        state_d  = state_q;
        count_d  = count_q;
        rem_d    = rem_q;
        quo_d    = quo_q;
        div_d    = div_q;
        neg_q_d  = neg_q_q;
        result_d = result_q;
        exc_d    = exc_q;
        rdy_d    = 1'b0;
`ifdef DIV_REMAINDER_EN
        neg_a_d  = neg_a_q;
        remout_d = remout_q;
`endif
        case (state_q)
            IDLE: begin
                if (ctrl_DIV) begin
                    neg_q_d = data_operandA[WIDTH-1] ^ data_operandB[WIDTH-1];
                    div_d   = abs_b;
                    quo_d   = abs_a;
                    rem_d   = '0;
                    count_d = '0;
`ifdef DIV_REMAINDER_EN
                    neg_a_d = data_operandA[WIDTH-1];
`endif
                    if (data_operandB == '0) begin
                        result_d = '0;
                        exc_d    = 1'b1;
                        rdy_d    = 1'b1;
`ifdef DIV_REMAINDER_EN
                        remout_d = '0;
`endif
                    end else if (data_operandA == MIN_VAL && data_operandB == ALL_ONES) begin
                        result_d = MIN_VAL;
                        exc_d    = 1'b1;
                        rdy_d    = 1'b1;
`ifdef DIV_REMAINDER_EN
                        remout_d = '0;
`endif
                    end else begin
                        state_d = RUN;
                    end
                end
            end
            RUN: begin
                count_d = count_q + 1'b1;
                if (!diff[WIDTH]) begin
                    rem_d = diff[WIDTH-1:0];
                    quo_d = {quo_q[WIDTH-2:0], 1'b1};
                end else begin
                    // Restore: the remainder stays below the divisor, so the top bit of partial is 0.
                    rem_d = partial[WIDTH-1:0];
                    quo_d = {quo_q[WIDTH-2:0], 1'b0};
                end
                if (count_q == LAST_STEP) begin
                    state_d = FIX;
                end
            end
            FIX: begin
                result_d = neg_q_q ? (~quo_q + 1'b1) : quo_q;
                exc_d    = 1'b0;
                rdy_d    = 1'b1;
`ifdef DIV_REMAINDER_EN
                remout_d = neg_a_q ? (~rem_q + 1'b1) : rem_q;
`endif
                state_d  = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and datapath registers; reset aborts any operation immediately.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q  <= IDLE;
            count_q  <= '0;
            rem_q    <= '0;
            quo_q    <= '0;
            div_q    <= '0;
            neg_q_q  <= 1'b0;
            result_q <= '0;
            exc_q    <= 1'b0;
            rdy_q    <= 1'b0;
`ifdef DIV_REMAINDER_EN
            neg_a_q  <= 1'b0;
            remout_q <= '0;
`endif
        end else begin
            state_q  <= state_d;
            count_q  <= count_d;
            rem_q    <= rem_d;
            quo_q    <= quo_d;
            div_q    <= div_d;
            neg_q_q  <= neg_q_d;
            result_q <= result_d;
            exc_q    <= exc_d;
            rdy_q    <= rdy_d;
`ifdef DIV_REMAINDER_EN
            neg_a_q  <= neg_a_d;
            remout_q <= remout_d;
`endif
        end
    end

    assign data_result    = result_q;
    assign data_exception = exc_q;
    assign data_resultRDY = rdy_q;
    assign busy           = (state_q != IDLE);
`ifdef DIV_REMAINDER_EN
    assign data_remainder = remout_q;
`endif

endmodule

// File: tb/tb_seq_divider.sv
// Self-checking bench for seq_divider: directed cases followed by randomized operands.
// Expected values come from signed 64-bit arithmetic.
module tb_seq_divider;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        ctrl_DIV = 1'b0;
    logic [31:0] data_operandA = '0;
    logic [31:0] data_operandB = '0;
    logic [31:0] data_result;
    logic        data_exception;
    logic        data_resultRDY;
    logic        busy;
`ifdef DIV_REMAINDER_EN
    logic [31:0] data_remainder;
`endif

    int checks = 0;
    int errors = 0;

    logic [31:0] last_q;
    logic        last_e;
    logic [31:0] last_r;

    seq_divider #(.WIDTH(32)) dut (
        .clock          (clock),
        .reset          (reset),
        .ctrl_DIV       (ctrl_DIV),
        .data_operandA  (data_operandA),
        .data_operandB  (data_operandB),
        .data_result    (data_result),
        .data_exception (data_exception),
        .data_resultRDY (data_resultRDY),
`ifdef DIV_REMAINDER_EN
        .data_remainder (data_remainder),
`endif
        .busy           (busy)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Reference: signed division truncating toward zero, with the two exception cases.
    function automatic void model(input logic [31:0] a, input logic [31:0] b,
                                  output logic [31:0] q, output logic e,
                                  output logic [31:0] r, output int lat);
        longint sa, sb, sq, sr;
        if (b == 32'h0) begin
            q = 32'h0; e = 1'b1; r = 32'h0; lat = 0;
        end else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
            q = 32'h8000_0000; e = 1'b1; r = 32'h0; lat = 0;
        end else begin
            sa = longint'($signed(a));
            sb = longint'($signed(b));
            sq = sa / sb;
            sr = sa - sq * sb;
            q = sq[31:0]; e = 1'b0; r = sr[31:0]; lat = 33;
        end
    endfunction

    // Entered at a falling edge; returns at the falling edge of the RDY cycle.
    // inject > 0 pulses ctrl_DIV with 9/3 so that it is sampled at edge 'inject'.
    task automatic do_div(input logic [31:0] a, input logic [31:0] b, input int inject);
        logic [31:0] eq, er;
        logic        ee;
        int          lat, k;
        model(a, b, eq, ee, er, lat);
        data_operandA = a;
        data_operandB = b;
        ctrl_DIV = 1'b1;
        @(posedge clock);
        @(negedge clock);
        ctrl_DIV = 1'b0;
        k = 0;
        while (!data_resultRDY && k < 40) begin
            check("busy_run", {31'b0, busy}, 32'd1);
            if (k == inject - 1) begin
                ctrl_DIV = 1'b1;
                data_operandA = 32'd9;
                data_operandB = 32'd3;
            end else begin
                ctrl_DIV = 1'b0;
                data_operandA = $urandom;
                data_operandB = $urandom;
            end
            @(posedge clock);
            @(negedge clock);
            k++;
        end
        ctrl_DIV = 1'b0;
        $display("div a=%h b=%h -> q=%h e=%0d edges=%0d (exp q=%h e=%0d edges=%0d)",
                 a, b, data_result, data_exception, k, eq, ee, lat);
        check("rdy", {31'b0, data_resultRDY}, 32'd1);
        check("latency", 32'(k), 32'(lat));
        check("busy_rdy", {31'b0, busy}, 32'd0);
        check("result", data_result, eq);
        check("exception", {31'b0, data_exception}, {31'b0, ee});
`ifdef DIV_REMAINDER_EN
        check("remainder", data_remainder, er);
`endif
        last_q = eq;
        last_e = ee;
        last_r = er;
    endtask

    // One idle cycle: RDY must have dropped and the result must be held.
    task automatic idle_tick();
        ctrl_DIV = 1'b0;
        data_operandA = $urandom;
        data_operandB = $urandom;
        @(posedge clock);
        @(negedge clock);
        check("rdy_pulse", {31'b0, data_resultRDY}, 32'd0);
        check("busy_idle", {31'b0, busy}, 32'd0);
        check("hold_result", data_result, last_q);
        check("hold_exc", {31'b0, data_exception}, {31'b0, last_e});
`ifdef DIV_REMAINDER_EN
        check("hold_rem", data_remainder, last_r);
`endif
    endtask

    initial begin
        logic [31:0] ra, rb;
        int          sel;

        // Reset state
        #3;
        check("reset_result", data_result, 32'h0);
        check("reset_exc", {31'b0, data_exception}, 32'd0);
        check("reset_rdy", {31'b0, data_resultRDY}, 32'd0);
        check("reset_busy", {31'b0, busy}, 32'd0);
        @(negedge clock);
        reset = 1'b1;
        @(negedge clock);

        // Basic signs
        do_div(32'd100, 32'd7, 0);
        check("t1_literal", data_result, 32'd14);
        idle_tick();
        do_div(32'hFFFF_FF9C, 32'd7, 0);
        check("t2_literal", data_result, 32'hFFFF_FFF2);
        idle_tick();
        do_div(32'd100, 32'hFFFF_FFF9, 0);
        idle_tick();

        // Fast paths and the MIN / 1 boundary
        do_div(32'd5, 32'd0, 0);
        idle_tick();
        do_div(32'h8000_0000, 32'hFFFF_FFFF, 0);
        idle_tick();
        do_div(32'h8000_0000, 32'd1, 0);
        check("t4_literal", data_result, 32'h8000_0000);
        idle_tick();

        // Start ignored while busy, then back-to-back start in the RDY cycle
        do_div(32'd100, 32'd7, 10);
        do_div(32'd9, 32'd3, 0);
        idle_tick();

        // Reset mid-operation
        data_operandA = 32'd1000;
        data_operandB = 32'd3;
        ctrl_DIV = 1'b1;
        @(posedge clock);
        @(negedge clock);
        ctrl_DIV = 1'b0;
        repeat (15) @(posedge clock);
        #2 reset = 1'b0;
        #1;
        $display("reset at edge 15: q=%h e=%0d rdy=%0d busy=%0d",
                 data_result, data_exception, data_resultRDY, busy);
        check("abort_result", data_result, 32'h0);
        check("abort_exc", {31'b0, data_exception}, 32'd0);
        check("abort_rdy", {31'b0, data_resultRDY}, 32'd0);
        check("abort_busy", {31'b0, busy}, 32'd0);
        repeat (3) begin
            @(negedge clock);
            check("abort_no_rdy", {31'b0, data_resultRDY}, 32'd0);
        end
        reset = 1'b1;
        @(negedge clock);
        do_div(32'hFFFF_FFF9, 32'd2, 0);
        check("t6_literal", data_result, 32'hFFFF_FFFD);
        idle_tick();

        // Randomized operands
        for (int i = 0; i < 24; i++) begin
            ra  = (i % 4 == 0) ? 32'h8000_0000 : $urandom;
            sel = $urandom_range(0, 5);
            case (sel)
                0:       rb = $urandom;
                1:       rb = $urandom_range(1, 20);
                2:       rb = -$urandom_range(1, 20);
                3:       rb = 32'h0;
                4:       rb = 32'hFFFF_FFFF;
                default: rb = $urandom >> $urandom_range(0, 31);
            endcase
            do_div(ra, rb, 0);
            if ($urandom_range(0, 1) == 1) idle_tick();
        end
        idle_tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
